// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider, one 33-bit trial subtract per cycle,
// quotient truncated toward zero and remainder signed like the dividend.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, a_q, a_d, q_q, q_d, r_q, r_d;
    logic sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, done_q, done_d, dbz_q, dbz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] trial;
    // Dividend magnitude rides in quo and shifts into rem one bit per iteration.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        a_d     = a_q;
        q_d     = q_q;
        r_d     = r_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = A;
                sa_d    = A[WIDTH-1];
                sb_d    = B[WIDTH-1];
                quo_d   = A[WIDTH-1] ? -A : A;
                div_d   = B[WIDTH-1] ? -B : B;
                bz_d    = (B == '0);
                rem_d   = '0;
                cnt_d   = '0;
            end
            RUN: begin
                rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = bz_q;
                q_d     = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo_q : quo_q);
                r_d     = bz_q ? a_q : (sa_q ? -rem_q : rem_q);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            a_q     <= a_d;
            q_q     <= q_d;
            r_q     <= r_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Quotient  = q_q;
    assign Remainder = r_q;
    assign dbz       = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus hand-written sequences for reset, ignored
// starts and back-to-back operation.
module tb_seq_divider;
    logic clk = 1'b0, clr = 1'b1, start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, dbz;
    logic [31:0] Quotient, Remainder;
    int checks = 0, errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, q, r;
        logic        dz;
    } vec_t;
    vec_t v[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one op, scramble the inputs, then count edges until done (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nd, dc1, dc2;
        logic [31:0] q1, r1, q2, r2;
        v[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        v[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        v[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
        v[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
        v[4]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        v[5]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
        v[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        v[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
        v[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
        v[9]  = '{32'h80000000, 32'd3,        32'hD5555556, 32'hFFFFFFFE, 1'b0};
        v[10] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
        v[11] = '{32'd7,        32'd100,      32'd0,        32'd7,        1'b0};
        v[12] = '{32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        v[13] = '{32'h7FFFFFFF, 32'd2,        32'h3FFFFFFF, 32'd1,        1'b0};
        v[14] = '{32'd1000,     32'd7,        32'd142,      32'd6,        1'b0};

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_dbz", {31'b0, dbz}, 32'd0);
        check("reset_q", Quotient, 32'd0);
        check("reset_r", Remainder, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(v[i].a, v[i].b, lat);
            check($sformatf("latency[%0d]", i), lat, 32'd33);
            check($sformatf("quot[%0d]", i), Quotient, v[i].q);
            check($sformatf("rem[%0d]", i), Remainder, v[i].r);
            check($sformatf("dbz[%0d]", i), {31'b0, dbz}, {31'b0, v[i].dz});
            @(negedge clk);
            check($sformatf("done_one_cycle[%0d]", i), {31'b0, done}, 32'd0);
        end

        // Asynchronous clear mid-run discards the op and zeroes the outputs.
        @(negedge clk);
        A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_busy", {31'b0, busy}, 32'd0);
        check("clr_q", Quotient, 32'd0);
        check("clr_r", Remainder, 32'd0);
        check("clr_dbz", {31'b0, dbz}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("clr_no_done", nd, 32'd0);
        run_op(32'd1000, 32'd3, lat);
        check("after_clr_latency", lat, 32'd33);
        check("after_clr_q", Quotient, 32'd333);
        check("after_clr_r", Remainder, 32'd1);

        // Starts during RUN and FIX are ignored.
        @(negedge clk);
        A = 32'd50; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; dc1 = 0; q1 = '0; r1 = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin dc1 = c; q1 = Quotient; r1 = Remainder; end
            end
            start = (c == 5 || c == 20 || c == 32);
            A = 32'd1000; B = 32'd10;
        end
        check("ignore_done_count", nd, 32'd1);
        check("ignore_latency", dc1, 32'd33);
        check("ignore_q", q1, 32'd8);
        check("ignore_r", r1, 32'd2);

        // start held high: back-to-back ops, second uses A/B present after first done.
        @(negedge clk);
        A = 32'd20; B = 32'd3; start = 1'b1;
        @(negedge clk);
        A = 32'd45; B = 32'd4;
        nd = 0; dc1 = 0; dc2 = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin dc1 = c; q1 = Quotient; r1 = Remainder; end
                if (nd == 2) begin dc2 = c; q2 = Quotient; r2 = Remainder; end
            end
            if (c == 67) start = 1'b0;
        end
        check("b2b_done_count", nd, 32'd2);
        check("b2b_first_latency", dc1, 32'd33);
        check("b2b_interval", dc2 - dc1, 32'd34);
        check("b2b_q1", q1, 32'd6);
        check("b2b_r1", r1, 32'd2);
        check("b2b_q2", q2, 32'd11);
        check("b2b_r2", r2, 32'd1);
        check("b2b_idle_after", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
